// File: rtl/sprite_pkg.sv
// Shared types and constants for the multi-sprite colour mapper.
// Used by sprite_color_mapper and circle_hit_pipe.
package sprite_pkg;

   localparam int         CW_DEFAULT       = 10;
   localparam logic [7:0] BG_BLUE0_DEFAULT = 8'h7F;
   localparam int         BG_SHIFT         = 3;

   typedef logic [CW_DEFAULT-1:0] coord_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t size;
      rgb_t   rgb;
      logic   vis;
   } sprite_t;

   // Index width that never collapses to zero bits for a single sprite.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/circle_hit_pipe.sv
// Per-sprite circle test: registered deltas, registered squared distance/radius,
// then the inside-circle compare that the top registers together with the colour.
module circle_hit_pipe
   import sprite_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [CW-1:0] DrawX,
   input  logic [CW-1:0] DrawY,
   input  logic [CW-1:0] x,
   input  logic [CW-1:0] y,
   input  logic [CW-1:0] size,
   input  logic          vis,
   output logic          hit
);

   localparam int D2W = 2*CW + 1;

   logic signed [CW:0]     dx_reg, dy_reg;
   logic [CW-1:0]          r_reg;
   logic                   vis1_reg;
   logic signed [2*CW+1:0] dx_sq, dy_sq;
   logic [D2W-1:0]         d2_next, d2_reg;
   logic [2*CW-1:0]        r2_next, r2_reg;
   logic                   vis2_reg;

   // Squares of signed deltas are never negative, so the sum fits D2W bits.
   assign dx_sq   = dx_reg * dx_reg;
   assign dy_sq   = dy_reg * dy_reg;
   assign d2_next = D2W'($unsigned(dx_sq + dy_sq));
   assign r2_next = (2*CW)'(r_reg) * (2*CW)'(r_reg);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         dx_reg   <= '0;
         dy_reg   <= '0;
         r_reg    <= '0;
         vis1_reg <= 1'b0;
         d2_reg   <= '0;
         r2_reg   <= '0;
         vis2_reg <= 1'b0;
      end else begin
         dx_reg   <= $signed({1'b0, DrawX}) - $signed({1'b0, x});
         dy_reg   <= $signed({1'b0, DrawY}) - $signed({1'b0, y});
         r_reg    <= size;
         vis1_reg <= vis;
         d2_reg   <= d2_next;
         r2_reg   <= r2_next;
         vis2_reg <= vis1_reg;
      end
   end

   assign hit = vis2_reg && (d2_reg <= {1'b0, r2_reg});

endmodule

// File: rtl/sprite_color_mapper.sv
// Multi-sprite VGA colour mapper: shadow/active sprite registers, per-sprite hit
// pipes, lowest-index priority and background gradient. Optional COLLISION_DETECT_EN.
module sprite_color_mapper
   import sprite_pkg::*;
#(
   parameter  int         N_SPRITES = 4,
   parameter  int         CW        = CW_DEFAULT,
   parameter  logic [7:0] BG_BLUE0  = BG_BLUE0_DEFAULT,
   localparam int         IW        = idx_width(N_SPRITES)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [CW-1:0] DrawX,
   input  logic [CW-1:0] DrawY,
   input  logic          blank,
   input  logic          frame_start,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [CW-1:0] wr_x,
   input  logic [CW-1:0] wr_y,
   input  logic [CW-1:0] wr_size,
   input  logic [23:0]   wr_rgb,
   input  logic          wr_vis,
   output logic [7:0]    Red,
   output logic [7:0]    Green,
   output logic [7:0]    Blue,
   output logic          pix_valid,
   output logic [IW-1:0] hit_idx,
   output logic          collision
);

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [CW-1:0] size;
      rgb_t          rgb;
      logic          vis;
   } spr_t;

   spr_t                 shadow_reg [N_SPRITES];
   spr_t                 active_reg [N_SPRITES];
   spr_t                 wr_spr;
   rgb_t                 rgb_s1_reg [N_SPRITES];
   rgb_t                 rgb_s2_reg [N_SPRITES];
   logic [N_SPRITES-1:0] hit;
   logic                 blank_s1_reg, blank_s2_reg;
   logic [7:0]           bg_b_next, bg_b_s1_reg, bg_b_s2_reg;
   logic [IW-1:0]        win_idx;
   logic                 win_hit;
   rgb_t                 win_rgb;
   logic [7:0]           red_reg, green_reg, blue_reg;
   logic                 pix_valid_reg;
   logic [IW-1:0]        hit_idx_reg;

   assign wr_spr = '{x: wr_x, y: wr_y, size: wr_size, rgb: rgb_t'(wr_rgb), vis: wr_vis};

   // Commit copies shadow as it stood before this cycle's write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N_SPRITES; i++) begin
            shadow_reg[i] <= '0;
            active_reg[i] <= '0;
         end
      end else begin
         if (frame_start) begin
            for (int i = 0; i < N_SPRITES; i++) active_reg[i] <= shadow_reg[i];
         end
         if (wr_en && (int'(wr_idx) < N_SPRITES)) shadow_reg[wr_idx] <= wr_spr;
      end
   end

   generate
      for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
         circle_hit_pipe #(.CW(CW)) u_pipe (
            .Clk   (Clk),
            .Reset (Reset),
            .DrawX (DrawX),
            .DrawY (DrawY),
            .x     (active_reg[gi].x),
            .y     (active_reg[gi].y),
            .size  (active_reg[gi].size),
            .vis   (active_reg[gi].vis),
            .hit   (hit[gi])
         );

         // Colour travels with the geometry so a mid-frame commit stays coherent.
         always_ff @(posedge Clk) begin
            if (Reset) begin
               rgb_s1_reg[gi] <= '0;
               rgb_s2_reg[gi] <= '0;
            end else begin
               rgb_s1_reg[gi] <= active_reg[gi].rgb;
               rgb_s2_reg[gi] <= rgb_s1_reg[gi];
            end
         end
      end
   endgenerate

   assign bg_b_next = BG_BLUE0 - 8'(DrawX >> BG_SHIFT);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         blank_s1_reg <= 1'b0;
         blank_s2_reg <= 1'b0;
         bg_b_s1_reg  <= '0;
         bg_b_s2_reg  <= '0;
      end else begin
         blank_s1_reg <= blank;
         blank_s2_reg <= blank_s1_reg;
         bg_b_s1_reg  <= bg_b_next;
         bg_b_s2_reg  <= bg_b_s1_reg;
      end
   end

   always_comb begin
      win_idx = '0;
      win_hit = 1'b0;
      win_rgb = '0;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_idx = IW'(i);
            win_hit = 1'b1;
            win_rgb = rgb_s2_reg[i];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         red_reg       <= '0;
         green_reg     <= '0;
         blue_reg      <= '0;
         pix_valid_reg <= 1'b0;
         hit_idx_reg   <= '0;
      end else begin
         pix_valid_reg <= blank_s2_reg;
         if (!blank_s2_reg) begin
            red_reg     <= '0;
            green_reg   <= '0;
            blue_reg    <= '0;
            hit_idx_reg <= '0;
         end else if (win_hit) begin
            red_reg     <= win_rgb.r;
            green_reg   <= win_rgb.g;
            blue_reg    <= win_rgb.b;
            hit_idx_reg <= win_idx;
         end else begin
            red_reg     <= '0;
            green_reg   <= '0;
            blue_reg    <= bg_b_s2_reg;
            hit_idx_reg <= '0;
         end
      end
   end

   assign Red       = red_reg;
   assign Green     = green_reg;
   assign Blue      = blue_reg;
   assign pix_valid = pix_valid_reg;
   assign hit_idx   = hit_idx_reg;

`ifdef COLLISION_DETECT_EN
   logic collision_reg;
   logic multi_hit;

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign multi_hit = |(hit & (hit - N_SPRITES'(1)));

   always_ff @(posedge Clk) begin
      if (Reset)                           collision_reg <= 1'b0;
      else if (blank_s2_reg && multi_hit)  collision_reg <= 1'b1;
      else if (frame_start)                collision_reg <= 1'b0;
   end

   assign collision = collision_reg;
`else
   assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Self-checking bench for sprite_color_mapper: directed scenarios plus a random
// back-to-back pixel stream compared against a geometric reference model.
module tb_sprite_color_mapper;

   localparam int N  = 4;
   localparam int CW = 10;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [CW-1:0] DrawX, DrawY;
   logic          blank, frame_start, wr_en;
   logic [1:0]    wr_idx;
   logic [CW-1:0] wr_x, wr_y, wr_size;
   logic [23:0]   wr_rgb;
   logic          wr_vis;
   logic [7:0]    Red, Green, Blue;
   logic          pix_valid;
   logic [1:0]    hit_idx;
   logic          collision;

   int checks = 0;
   int errors = 0;

   // Reference model: sprite state as the spec describes it.
   int          sh_x[N], sh_y[N], sh_s[N], ac_x[N], ac_y[N], ac_s[N];
   logic [23:0] sh_rgb[N], ac_rgb[N];
   bit          sh_vis[N], ac_vis[N];

   typedef struct {
      logic [23:0] rgb;
      int          idx;
      bit          v;
   } exp_t;

   sprite_color_mapper #(.N_SPRITES(N), .CW(CW), .BG_BLUE0(8'h7F)) dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
      .wr_y(wr_y), .wr_size(wr_size), .wr_rgb(wr_rgb), .wr_vis(wr_vis),
      .Red(Red), .Green(Green), .Blue(Blue), .pix_valid(pix_valid),
      .hit_idx(hit_idx), .collision(collision)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         sh_x[i] = 0; sh_y[i] = 0; sh_s[i] = 0; sh_rgb[i] = 0; sh_vis[i] = 0;
         ac_x[i] = 0; ac_y[i] = 0; ac_s[i] = 0; ac_rgb[i] = 0; ac_vis[i] = 0;
      end
   endfunction

   function automatic void model_commit();
      for (int i = 0; i < N; i++) begin
         ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_s[i] = sh_s[i];
         ac_rgb[i] = sh_rgb[i]; ac_vis[i] = sh_vis[i];
      end
   endfunction

   function automatic void model_pix(input int x, input int y, input bit b,
                                     output logic [23:0] rgb, output int idx);
      rgb = 24'h0;
      idx = 0;
      if (!b) return;
      rgb = {16'h0, 8'(8'h7F - (x / 8))};
      for (int i = N - 1; i >= 0; i--) begin
         if (ac_vis[i] && ((x - ac_x[i]) * (x - ac_x[i]) + (y - ac_y[i]) * (y - ac_y[i])
                           <= ac_s[i] * ac_s[i])) begin
            rgb = ac_rgb[i];
            idx = i;
         end
      end
   endfunction

   task automatic write_spr(input int idx, input int x, input int y, input int s,
                            input logic [23:0] rgb, input bit vis, input bit fs);
      @(negedge Clk);
      wr_en = 1'b1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y);
      wr_size = 10'(s); wr_rgb = rgb; wr_vis = vis; frame_start = fs;
      if (fs) model_commit();
      sh_x[idx] = x; sh_y[idx] = y; sh_s[idx] = s; sh_rgb[idx] = rgb; sh_vis[idx] = vis;
      @(negedge Clk);
      wr_en = 1'b0; frame_start = 1'b0;
   endtask

   task automatic commit();
      @(negedge Clk);
      frame_start = 1'b1;
      model_commit();
      @(negedge Clk);
      frame_start = 1'b0;
   endtask

   task automatic probe(input int x, input int y, input bit b,
                        output logic [23:0] rgb, output logic [1:0] idx, output logic v);
      @(negedge Clk);
      DrawX = 10'(x); DrawY = 10'(y); blank = b;
      repeat (3) @(posedge Clk);
      #1;
      rgb = {Red, Green, Blue}; idx = hit_idx; v = pix_valid;
   endtask

   task automatic test_reset();
      Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1; frame_start = 1'b0;
      wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_size = '0; wr_rgb = '0; wr_vis = 1'b0;
      model_clear();
      repeat (4) @(posedge Clk);
      #1;
      checks++; if ({Red, Green, Blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", {Red, Green, Blue}); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
      checks++; if (hit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", hit_idx); end
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b expected 0", collision); end
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_background();
      logic [23:0] rgb; logic [1:0] idx; logic v;
      probe(0, 10, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h00007F) begin errors++; $display("FAIL bg_x0: got %h expected 00007F", rgb); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL bg_valid: got %b expected 1", v); end
      probe(640, 10, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h00002F) begin errors++; $display("FAIL bg_x640: got %h expected 00002F", rgb); end
      $display("background: x0 and x640 probed");
   endtask

   task automatic test_single_sprite();
      logic [23:0] rgb, e; logic [1:0] idx; logic v; int ei;
      write_spr(0, 320, 240, 10, 24'hBB5500, 1'b1, 1'b0);
      probe(320, 250, 1'b1, rgb, idx, v);
      model_pix(320, 250, 1'b1, e, ei);
      checks++; if (rgb !== e) begin errors++; $display("FAIL precommit: got %h expected %h", rgb, e); end
      commit();
      probe(320, 250, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'hBB5500 || idx !== 2'd0) begin errors++; $display("FAIL edge_in: got %h/%0d expected BB5500/0", rgb, idx); end
      probe(320, 251, 1'b1, rgb, idx, v);
      model_pix(320, 251, 1'b1, e, ei);
      checks++; if (rgb !== e) begin errors++; $display("FAIL edge_out: got %h expected %h", rgb, e); end
      $display("single_sprite: commit and radius edge probed");
   endtask

   task automatic test_priority();
      logic [23:0] rgb; logic [1:0] idx; logic v;
      write_spr(0, 100, 100, 5, 24'h112233, 1'b1, 1'b0);
      write_spr(2, 102, 100, 8, 24'h445566, 1'b1, 1'b0);
      commit();
      probe(100, 100, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h112233 || idx !== 2'd0) begin errors++; $display("FAIL prio_low: got %h/%0d expected 112233/0", rgb, idx); end
      write_spr(0, 100, 100, 5, 24'h112233, 1'b0, 1'b0);
      commit();
      probe(100, 100, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h445566 || idx !== 2'd2) begin errors++; $display("FAIL prio_vis0: got %h/%0d expected 445566/2", rgb, idx); end
      $display("priority: overlapping sprites 0 and 2 probed");
   endtask

   task automatic test_commit_race();
      logic [23:0] rgb, e; logic [1:0] idx; logic v; int ei;
      write_spr(1, 500, 400, 3, 24'h00FF00, 1'b1, 1'b0);
      commit();
      write_spr(1, 600, 400, 3, 24'h00FF00, 1'b1, 1'b1);
      probe(500, 400, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h00FF00 || idx !== 2'd1) begin errors++; $display("FAIL race_old: got %h/%0d expected 00FF00/1", rgb, idx); end
      probe(600, 400, 1'b1, rgb, idx, v);
      model_pix(600, 400, 1'b1, e, ei);
      checks++; if (rgb !== e || e === 24'h00FF00) begin errors++; $display("FAIL race_new_hidden: got %h expected %h", rgb, e); end
      commit();
      probe(600, 400, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h00FF00 || idx !== 2'd1) begin errors++; $display("FAIL race_new_shown: got %h/%0d expected 00FF00/1", rgb, idx); end
      $display("commit_race: write during frame_start probed");
   endtask

   task automatic test_edges();
      logic [23:0] rgb, e; logic [1:0] idx; logic v; int ei;
      write_spr(3, 5, 300, 20, 24'hA0B0C0, 1'b1, 1'b0);
      commit();
      probe(0, 300, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'hA0B0C0 || idx !== 2'd3) begin errors++; $display("FAIL clip_left: got %h/%0d expected A0B0C0/3", rgb, idx); end
      probe(1020, 300, 1'b1, rgb, idx, v);
      model_pix(1020, 300, 1'b1, e, ei);
      checks++; if (rgb !== e || idx !== 2'd0) begin errors++; $display("FAIL no_wrap: got %h/%0d expected %h/0", rgb, idx, e); end
      probe(0, 300, 1'b0, rgb, idx, v);
      checks++; if (rgb !== 24'h0 || v !== 1'b0) begin errors++; $display("FAIL blanked: got %h valid %b expected 000000 valid 0", rgb, v); end
      write_spr(3, 700, 50, 0, 24'h123456, 1'b1, 1'b0);
      commit();
      probe(700, 50, 1'b1, rgb, idx, v);
      checks++; if (rgb !== 24'h123456) begin errors++; $display("FAIL size0_centre: got %h expected 123456", rgb); end
      probe(701, 50, 1'b1, rgb, idx, v);
      model_pix(701, 50, 1'b1, e, ei);
      checks++; if (rgb !== e || e === 24'h123456) begin errors++; $display("FAIL size0_side: got %h expected %h", rgb, e); end
      probe(700, 51, 1'b1, rgb, idx, v);
      model_pix(700, 51, 1'b1, e, ei);
      checks++; if (rgb !== e || e === 24'h123456) begin errors++; $display("FAIL size0_below: got %h expected %h", rgb, e); end
      $display("edges: clipping, blank and size 0 probed");
   endtask

   task automatic test_collision();
      logic [23:0] rgb; logic [1:0] idx; logic v;
      write_spr(0, 200, 200, 10, 24'hFF0000, 1'b1, 1'b0);
      write_spr(1, 205, 200, 10, 24'h0000FF, 1'b1, 1'b0);
      commit();
      probe(230, 200, 1'b1, rgb, idx, v);
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b expected 0", collision); end
      probe(203, 200, 1'b1, rgb, idx, v);
`ifdef COLLISION_DETECT_EN
      checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_set: got %b expected 1", collision); end
      probe(500, 10, 1'b1, rgb, idx, v);
      checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %b expected 1", collision); end
      commit();
      #1;
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_commit: got %b expected 0", collision); end
      probe(203, 200, 1'b1, rgb, idx, v);
      @(negedge Clk); Reset = 1'b1;
      @(posedge Clk); #1;
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_reset: got %b expected 0", collision); end
      @(negedge Clk); Reset = 1'b0;
      model_clear();
`else
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_tied: got %b expected 0", collision); end
`endif
      $display("collision: overlap pixel probed, flag %b", collision);
   endtask

   task automatic test_midframe_reset();
      @(negedge Clk);
      DrawX = 10'd40; DrawY = 10'd40; blank = 1'b1;
      repeat (4) @(posedge Clk);
      @(negedge Clk); Reset = 1'b1;
      @(posedge Clk); #1;
      checks++; if (pix_valid !== 1'b0 || {Red, Green, Blue} !== 24'h0) begin errors++; $display("FAIL midreset_flush: got %h valid %b expected 000000 valid 0", {Red, Green, Blue}, pix_valid); end
      @(negedge Clk); Reset = 1'b0;
      model_clear();
      repeat (2) @(posedge Clk); #1;
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL midreset_early: got %b expected 0", pix_valid); end
      @(posedge Clk); #1;
      checks++; if (pix_valid !== 1'b1 || {Red, Green, Blue} !== 24'h00007A) begin errors++; $display("FAIL midreset_resume: got %h valid %b expected 00007A valid 1", {Red, Green, Blue}, pix_valid); end
      $display("midframe_reset: pipeline flush probed");
   endtask

   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      int   npix = 400;
      for (int i = 0; i < N; i++)
         write_spr(i, $urandom_range(1023), $urandom_range(767), $urandom_range(60),
                   24'($urandom), 1'($urandom_range(3) != 0), 1'b0);
      commit();
      for (int c = 0; c < npix + 3; c++) begin
         int k, px, py;
         bit b;
         @(negedge Clk);
         if (c >= 3) begin
            e = q.pop_front();
            checks++;
            if ({Red, Green, Blue} !== e.rgb || hit_idx !== 2'(e.idx) || pix_valid !== e.v) begin
               errors++;
               $display("FAIL stream[%0d]: got %h/%0d/%b expected %h/%0d/%b", c - 3,
                        {Red, Green, Blue}, hit_idx, pix_valid, e.rgb, e.idx, e.v);
            end
`ifndef COLLISION_DETECT_EN
            checks++; if (collision !== 1'b0) begin errors++; $display("FAIL stream_coll[%0d]: got %b expected 0", c - 3, collision); end
`endif
         end
         k  = $urandom_range(N - 1);
         px = (ac_x[k] + $urandom_range(140) - 70) & 1023;
         py = (ac_y[k] + $urandom_range(140) - 70) & 1023;
         b  = (c < npix) && ($urandom_range(7) != 0);
         DrawX = 10'(px); DrawY = 10'(py); blank = b;
         model_pix(px, py, b, e.rgb, e.idx);
         e.v = b;
         q.push_back(e);
         frame_start = ($urandom_range(39) == 0);
         if (frame_start) model_commit();
         wr_en = ($urandom_range(9) == 0);
         if (wr_en) begin
            k = $urandom_range(N - 1);
            wr_idx = 2'(k); wr_x = 10'($urandom); wr_y = 10'($urandom_range(767));
            wr_size = 10'($urandom_range(60)); wr_rgb = 24'($urandom); wr_vis = 1'($urandom_range(3) != 0);
            sh_x[k] = int'(wr_x); sh_y[k] = int'(wr_y); sh_s[k] = int'(wr_size);
            sh_rgb[k] = wr_rgb; sh_vis[k] = wr_vis;
         end
      end
      @(negedge Clk);
      wr_en = 1'b0; frame_start = 1'b0;
      $display("back_to_back: %0d streamed pixels compared", npix);
   endtask

   initial begin
      test_reset();
      test_background();
      test_single_sprite();
      test_priority();
      test_commit_race();
      test_edges();
      test_collision();
      test_midframe_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
